// File: rtl/tk1_pkg.sv
// Shared constants for the reverse-order Romulus-N TK1 schedule:
// tweak permutation tables, FSM state encoding and counter width.
package tk1_pkg;

  localparam int CNT_W = 6;

  // cell i of the result takes old cell PT[i] / PTI[i]; cell i = TK[127-8i -: 8]
  localparam int PT  [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
  localparam int PTI [16] = '{8, 9, 10, 11, 12, 13, 14, 15, 2, 0, 4, 7, 6, 3, 5, 1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2
  } state_t;

endpackage

// File: rtl/tk1_rewind_perm.sv
// Combinational SKINNY tweak permutations: forward PT (TweakPerm) and
// inverse PTI (TweakPermInv). Pure byte rewiring.
module TweakPerm
  import tk1_pkg::*;
(
  input  logic [127:0] tk,
  output logic [127:0] tk_perm
);

  for (genvar i = 0; i < 16; i++) begin : g_cell
    assign tk_perm[127-8*i -: 8] = tk[127-8*PT[i] -: 8];
  end

endmodule

module TweakPermInv
  import tk1_pkg::*;
(
  input  logic [127:0] tk,
  output logic [127:0] tk_perm
);

  for (genvar i = 0; i < 16; i++) begin : g_cell
    assign tk_perm[127-8*i -: 8] = tk[127-8*PTI[i] -: 8];
  end

endmodule

// File: rtl/tk1_rewind.sv
// Reverse-order TK1 generator: loads round-0 TK1, fast-forwards through
// ROUNDS-1 applications of PT, then walks back one round per consumed step.
module tk1_rewind
  import tk1_pkg::*;
#(
  parameter int ROUNDS = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] TK1_init,
  input  logic         step,
  output logic [127:0] TK1_round,
  output logic [5:0]   round_idx,
  output logic         ready,
  output logic         busy,
  output logic         done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_t             state, state_nx;
  logic [127:0]       tk, tk_nx, tk_fwd, tk_bwd;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic               done_r, done_nx;

  TweakPerm    u_perm     (.tk(tk), .tk_perm(tk_fwd));
  TweakPermInv u_perm_inv (.tk(tk), .tk_perm(tk_bwd));

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tk     <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      tk     <= tk_nx;
      cnt    <= cnt_nx;
      done_r <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tk_nx    = tk;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          tk_nx    = TK1_init;
          cnt_nx   = '0;
          state_nx = FWD;
        end
      end
      FWD: begin
        tk_nx  = tk_fwd;
        cnt_nx = cnt_inc;
        if (cnt_inc == LAST) state_nx = BWD;
      end
      BWD: begin
        // the step at round 0 leaves TK/cnt alone so round 0 stays on the output
        if (step) begin
          if (cnt != '0) begin
            tk_nx  = tk_bwd;
            cnt_nx = cnt - 1'b1;
          end else begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign TK1_round = tk;
  assign round_idx = cnt;
  assign ready     = (state == BWD);
  assign busy      = (state == FWD);
  assign done      = done_r;

endmodule
